coherence_bus_ctrl: RTL and testbench

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

---
 rtl/coherence_bus_ctrl.sv | 170 +++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// Two-cache snooping coherence bus controller: arbitrates writebacks and
// coherence transactions, sequences snoops, cache-to-cache and memory block moves.
module coherence_bus_ctrl #(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        ccif_dREN,
  input  logic [CPUS-1:0]        ccif_dWEN,
  input  logic [CPUS-1:0][31:0]  ccif_daddr,
  input  logic [CPUS-1:0][31:0]  ccif_dstore,
  input  logic [CPUS-1:0]        ccif_cctrans,
  input  logic [CPUS-1:0]        ccif_ccwrite,
  input  logic [CPUS-1:0]        ccif_halt,
  input  logic [CPUS-1:0]        ccif_flushed,
  output logic [CPUS-1:0]        ccif_dwait,
  output logic [CPUS-1:0][31:0]  ccif_dload,
  output logic [CPUS-1:0]        ccif_ccwait,
  output logic [CPUS-1:0]        ccif_ccinv,
  output logic [CPUS-1:0][31:0]  ccif_ccsnoopaddr,
  output logic                   dREN,
  output logic                   dWEN,
  output logic [31:0]            daddr,
  output logic [31:0]            dstore,
  input  logic                   dwait,
  input  logic [31:0]            dload
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] GRANT = 4'd1;
  localparam logic [3:0] SNOOP = 4'd2;
  localparam logic [3:0] C2C0  = 4'd3;
  localparam logic [3:0] C2C1  = 4'd4;
  localparam logic [3:0] MEM0  = 4'd5;
  localparam logic [3:0] MEM1  = 4'd6;
  localparam logic [3:0] WB0   = 4'd7;
  localparam logic [3:0] WB1   = 4'd8;
  localparam logic [3:0] UPG   = 4'd9;

  logic [3:0]      state, state_nxt;
  logic            ptr;       // round-robin owner: wins ties
  logic            req_q;     // requester R
  logic            snp_q;     // snooper S
  logic [CPUS-1:0] wb_req, cc_req, pend, cand;
  logic            grant_wb, win, xfer_done;

  // Halt is deliberately ignored: a halted core still arbitrates and is snooped.
  logic halt_unused;
  assign halt_unused = ^ccif_halt;

  // A flushed cache has written everything back and must not start traffic.
  assign wb_req = ccif_dWEN & ~ccif_flushed;
  assign cc_req = ccif_cctrans & ~ccif_flushed;
  assign pend   = wb_req | cc_req;

  always_comb begin
    grant_wb = |wb_req;
    cand     = grant_wb ? wb_req : cc_req;
    win      = cand[ptr] ? ptr : ~ptr;
  end

  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // otherwise the untouched paths infer latches.
  always_comb begin
    state_nxt = state;
    xfer_done = 1'b0;
    case (state)
      IDLE:  if (|pend) state_nxt = GRANT;
      GRANT: begin
        if (!(|cand))
          state_nxt = IDLE;
        else if (grant_wb)
          state_nxt = WB0;
        else if (ccif_cctrans[win] & ccif_ccwrite[win] & ~ccif_dREN[win])
          state_nxt = UPG;
        else
          state_nxt = SNOOP;
      end
      SNOOP: begin
        if (ccif_flushed[snp_q])
          state_nxt = MEM0;
        else if (ccif_cctrans[snp_q])
          state_nxt = ccif_ccwrite[snp_q] ? C2C0 : MEM0;
      end
      C2C0:  if (!dwait) state_nxt = C2C1;
      MEM0:  if (!dwait) state_nxt = MEM1;
      WB0:   if (!dwait) state_nxt = WB1;
      C2C1, MEM1, WB1: begin
        if (!dwait) begin
          state_nxt = IDLE;
          xfer_done = 1'b1;
        end
      end
      UPG: begin
        state_nxt = IDLE;
        xfer_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      ptr   <= 1'b0;
      req_q <= 1'b0;
      snp_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == GRANT && (|cand)) begin
        req_q <= win;
        snp_q <= ~win;
      end
      if (xfer_done) ptr <= ~req_q;
    end
  end

  // Outputs are decoded from the registered state, so reset forces the idle
  // values combinationally in the same cycle nRST falls.
  always_comb begin
    ccif_dwait       = '1;
    ccif_dload       = '0;
    ccif_ccwait      = '0;
    ccif_ccinv       = '0;
    ccif_ccsnoopaddr = '0;
    dREN             = 1'b0;
    dWEN             = 1'b0;
    daddr            = '0;
    dstore           = '0;
    case (state)
      SNOOP: begin
        ccif_ccwait[snp_q]      = 1'b1;
        ccif_ccinv[snp_q]       = ccif_ccwrite[req_q];
        ccif_ccsnoopaddr[snp_q] = ccif_daddr[req_q];
      end
      C2C0, C2C1: begin
        // Modified data goes to the requester and to memory in one transfer.
        dWEN                = 1'b1;
        daddr               = ccif_daddr[snp_q];
        dstore              = ccif_dstore[snp_q];
        ccif_dload[req_q]   = ccif_dstore[snp_q];
        ccif_ccwait[snp_q]  = 1'b1;
        ccif_dwait[req_q]   = dwait;
        ccif_dwait[snp_q]   = dwait;
      end
      MEM0, MEM1: begin
        dREN              = 1'b1;
        daddr             = ccif_daddr[req_q];
        ccif_dload[req_q] = dload;
        ccif_dwait[req_q] = dwait;
      end
      WB0, WB1: begin
        dWEN              = 1'b1;
        daddr             = ccif_daddr[req_q];
        dstore            = ccif_dstore[req_q];
        ccif_dwait[req_q] = dwait;
      end
      UPG: begin
        ccif_ccwait[snp_q]      = 1'b1;
        ccif_ccinv[snp_q]       = 1'b1;
        ccif_ccsnoopaddr[snp_q] = ccif_daddr[req_q];
        ccif_dwait[req_q]       = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: stimulus pushes expected bus cycles
// into a scoreboard queue; a negedge monitor pops and compares active cycles.
module tb_coherence_bus_ctrl;

  localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

  logic             CLK;
  logic             nRST;
  logic [1:0]       ccif_dREN, ccif_dWEN, ccif_cctrans, ccif_ccwrite;
  logic [1:0]       ccif_halt, ccif_flushed;
  logic [1:0][31:0] ccif_daddr, ccif_dstore;
  logic [1:0]       ccif_dwait, ccif_ccwait, ccif_ccinv;
  logic [1:0][31:0] ccif_dload, ccif_ccsnoopaddr;
  logic             dREN, dWEN, dwait;
  logic [31:0]      daddr, dstore, dload;

  typedef struct packed {
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  ccwait;
    logic [1:0]  ccinv;
    logic [31:0] snp1;
    logic [31:0] snp0;
    logic [1:0]  cdwait;
    logic [31:0] dload1;
    logic [31:0] dload0;
  } bus_t;

  bus_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  coherence_bus_ctrl #(.CPUS(2)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .ccif_dREN        (ccif_dREN),
    .ccif_dWEN        (ccif_dWEN),
    .ccif_daddr       (ccif_daddr),
    .ccif_dstore      (ccif_dstore),
    .ccif_cctrans     (ccif_cctrans),
    .ccif_ccwrite     (ccif_ccwrite),
    .ccif_halt        (ccif_halt),
    .ccif_flushed     (ccif_flushed),
    .ccif_dwait       (ccif_dwait),
    .ccif_dload       (ccif_dload),
    .ccif_ccwait      (ccif_ccwait),
    .ccif_ccinv       (ccif_ccinv),
    .ccif_ccsnoopaddr (ccif_ccsnoopaddr),
    .dREN             (dREN),
    .dWEN             (dWEN),
    .daddr            (daddr),
    .dstore           (dstore),
    .dwait            (dwait),
    .dload            (dload)
  );

  // Memory model: read data is a fixed function of the address.
  assign dload = daddr ^ MEM_KEY;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bus_t idle_b();
    bus_t b;
    b        = '0;
    b.cdwait = 2'b11;
    return b;
  endfunction

  task automatic push(input bus_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_dwait"}, 64'(ccif_dwait), 64'(2'b11));
    check({name, "_strobes"}, 64'({dREN, dWEN, ccif_ccwait, ccif_ccinv}), 64'd0);
    check({name, "_dload"}, 64'(ccif_dload), 64'd0);
  endtask

  // Monitor: every cycle with a memory strobe or snoop stall is a bus cycle.
  always @(negedge CLK) begin
    bus_t  act, e;
    string tag;
    if (nRST && (dREN || dWEN || (|ccif_ccwait))) begin
      act.dren   = dREN;
      act.dwen   = dWEN;
      act.daddr  = daddr;
      act.dstore = dstore;
      act.ccwait = ccif_ccwait;
      act.ccinv  = ccif_ccinv;
      act.snp1   = ccif_ccsnoopaddr[1];
      act.snp0   = ccif_ccsnoopaddr[0];
      act.cdwait = ccif_dwait;
      act.dload1 = ccif_dload[1];
      act.dload0 = ccif_dload[0];
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_bus_cycle: got %h expected no activity", act);
      end else begin
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", tag, act, e);
        end
      end
    end
  end

  initial begin
    bus_t e;
    nRST         = 1'b0;
    ccif_dREN    = '0;
    ccif_dWEN    = '0;
    ccif_cctrans = '0;
    ccif_ccwrite = '0;
    ccif_halt    = '0;
    ccif_flushed = '0;
    ccif_daddr   = '0;
    ccif_dstore  = '0;
    dwait        = 1'b0;
    #2;
    check_idle("reset");
    check("reset_daddr", 64'({daddr, dstore}), 64'd0);
    cyc();
    nRST = 1'b1;

    // Read miss from cache0; cache1 clean.
    ccif_dREN[0] = 1'b1; ccif_cctrans[0] = 1'b1; ccif_daddr[0] = 32'h100;
    cyc();                                       // GRANT
    cyc();                                       // SNOOP
    e = idle_b(); e.ccwait = 2'b10; e.snp1 = 32'h100;
    push(e, "rd_snoop");
    ccif_cctrans[1] = 1'b1;
    cyc();                                       // MEM0
    ccif_cctrans[1] = 1'b0;
    e = idle_b(); e.dren = 1'b1; e.daddr = 32'h100; e.cdwait = 2'b10;
    e.dload0 = 32'h100 ^ MEM_KEY;
    push(e, "rd_mem0");
    cyc();                                       // MEM1
    ccif_daddr[0] = 32'h104;
    e.daddr = 32'h104; e.dload0 = 32'h104 ^ MEM_KEY;
    push(e, "rd_mem1");
    cyc();                                       // IDLE
    ccif_dREN[0] = 1'b0; ccif_cctrans[0] = 1'b0;
    check_idle("rd_done");

    // BusRdX from cache1; cache0 holds the line Modified.
    ccif_dREN[1] = 1'b1; ccif_cctrans[1] = 1'b1; ccif_ccwrite[1] = 1'b1;
    ccif_daddr[1] = 32'h200;
    cyc();                                       // GRANT
    cyc();                                       // SNOOP
    e = idle_b(); e.ccwait = 2'b01; e.ccinv = 2'b01; e.snp0 = 32'h200;
    push(e, "rdx_snoop");
    ccif_cctrans[0] = 1'b1; ccif_ccwrite[0] = 1'b1;
    ccif_daddr[0] = 32'h200; ccif_dstore[0] = 32'hDEADBEEF;
    cyc();                                       // C2C0
    ccif_cctrans[0] = 1'b0;
    e = idle_b(); e.dwen = 1'b1; e.daddr = 32'h200; e.dstore = 32'hDEADBEEF;
    e.ccwait = 2'b01; e.cdwait = 2'b00; e.dload1 = 32'hDEADBEEF;
    push(e, "rdx_c2c0");
    cyc();                                       // C2C1
    ccif_daddr[0] = 32'h204; ccif_dstore[0] = 32'hCAFEF00D; ccif_daddr[1] = 32'h204;
    e.daddr = 32'h204; e.dstore = 32'hCAFEF00D; e.dload1 = 32'hCAFEF00D;
    push(e, "rdx_c2c1");
    cyc();                                       // IDLE, pointer back to 0
    ccif_dREN[1] = 1'b0; ccif_cctrans[1] = 1'b0; ccif_ccwrite = '0;
    check_idle("rdx_done");

    // Writeback from cache1 beats cache0 read despite pointer 0.
    ccif_dREN[0] = 1'b1; ccif_cctrans[0] = 1'b1; ccif_daddr[0] = 32'h300;
    ccif_dWEN[1] = 1'b1; ccif_daddr[1] = 32'h500; ccif_dstore[1] = 32'h11112222;
    cyc();                                       // GRANT
    cyc();                                       // WB0 stalled
    dwait = 1'b1;
    e = idle_b(); e.dwen = 1'b1; e.daddr = 32'h500; e.dstore = 32'h11112222;
    push(e, "wb0_stall");
    cyc();                                       // WB0 again
    dwait = 1'b0;
    e.cdwait = 2'b01;
    push(e, "wb0_go");
    cyc();                                       // WB1
    ccif_daddr[1] = 32'h504; ccif_dstore[1] = 32'h33334444;
    e.daddr = 32'h504; e.dstore = 32'h33334444;
    push(e, "wb1");
    cyc();                                       // IDLE
    ccif_dWEN[1] = 1'b0; ccif_flushed[1] = 1'b1;
    cyc();                                       // GRANT
    cyc();                                       // SNOOP of flushed cache1
    e = idle_b(); e.ccwait = 2'b10; e.snp1 = 32'h300;
    push(e, "after_wb_snoop");
    cyc();                                       // MEM0 without snoop reply
    e = idle_b(); e.dren = 1'b1; e.daddr = 32'h300; e.cdwait = 2'b10;
    e.dload0 = 32'h300 ^ MEM_KEY;
    push(e, "after_wb_mem0");
    cyc();                                       // MEM1
    ccif_daddr[0] = 32'h304;
    e.daddr = 32'h304; e.dload0 = 32'h304 ^ MEM_KEY;
    push(e, "after_wb_mem1");
    cyc();                                       // IDLE, pointer 1
    ccif_dREN[0] = 1'b0; ccif_cctrans[0] = 1'b0; ccif_flushed[1] = 1'b0;

    // Upgrade from cache0.
    ccif_cctrans[0] = 1'b1; ccif_ccwrite[0] = 1'b1; ccif_daddr[0] = 32'h40;
    cyc();                                       // GRANT
    cyc();                                       // UPG
    e = idle_b(); e.ccwait = 2'b10; e.ccinv = 2'b10; e.snp1 = 32'h40; e.cdwait = 2'b10;
    push(e, "upg");
    ccif_cctrans[0] = 1'b0; ccif_ccwrite[0] = 1'b0;
    cyc();                                       // IDLE
    check_idle("upg_done");

    // Cache1 read stalled in MEM0, then reset mid-transaction.
    ccif_dREN[1] = 1'b1; ccif_cctrans[1] = 1'b1; ccif_daddr[1] = 32'h600;
    cyc();                                       // GRANT
    cyc();                                       // SNOOP
    e = idle_b(); e.ccwait = 2'b01; e.snp0 = 32'h600;
    push(e, "rst_snoop");
    ccif_cctrans[0] = 1'b1;
    cyc();                                       // MEM0
    ccif_cctrans[0] = 1'b0;
    dwait = 1'b1;
    e = idle_b(); e.dren = 1'b1; e.daddr = 32'h600; e.dload1 = 32'h600 ^ MEM_KEY;
    for (int i = 0; i < 3; i++) begin
      push(e, "rst_mem0_wait");
      if (i < 2) cyc();
    end
    cyc();
    nRST = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_addr", 64'({daddr, dstore}), 64'd0);
    ccif_dREN = '0; ccif_cctrans = '0; dwait = 1'b0;
    cyc();
    nRST = 1'b1;

    // Both caches request together from reset; cache1 halted.
    ccif_halt[1] = 1'b1;
    ccif_dREN = 2'b11; ccif_cctrans = 2'b11;
    ccif_daddr[0] = 32'h700; ccif_daddr[1] = 32'h800;
    for (int k = 0; k < 3; k++) begin
      logic r;
      logic [31:0] a;
      r = k[0];
      a = r ? 32'h800 : 32'h700;
      cyc();                                     // GRANT
      cyc();                                     // SNOOP
      e = idle_b(); e.ccwait = r ? 2'b01 : 2'b10;
      if (r) e.snp0 = a; else e.snp1 = a;
      push(e, $sformatf("rr%0d_snoop", k));
      cyc();                                     // MEM0
      if (k == 2) begin
        ccif_dREN = '0; ccif_cctrans = '0;
      end
      e = idle_b(); e.dren = 1'b1; e.daddr = a; e.cdwait = r ? 2'b01 : 2'b10;
      if (r) e.dload1 = a ^ MEM_KEY; else e.dload0 = a ^ MEM_KEY;
      push(e, $sformatf("rr%0d_mem0", k));
      cyc();                                     // MEM1
      ccif_daddr[r] = a + 32'h4;
      e.daddr = a + 32'h4;
      if (r) e.dload1 = (a + 32'h4) ^ MEM_KEY; else e.dload0 = (a + 32'h4) ^ MEM_KEY;
      push(e, $sformatf("rr%0d_mem1", k));
      cyc();                                     // IDLE
      ccif_daddr[r] = a;
    end
    check_idle("rr_done");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    repeat (4) cyc();
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no bus cycle expected one", tag_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
